// File: rtl/execute_port_buffered.sv
// execute_port_buffered: single-cycle ALU whose results queue in a writeback FIFO.
// Issue is refused only when full; consumer pops the head with iNEXT_READY.
module execute_port_buffered #(
  parameter int P_DATA_WIDTH = 32,
  parameter int P_TAG_WIDTH = 6,
  parameter int P_REG_WIDTH = 6,
  parameter int P_DEPTH = 4
) (
  input  logic                      iCLOCK,
  input  logic                      inRESET,
  input  logic                      iFREE_EX,
  input  logic                      iPREV_VALID,
  input  logic [3:0]                iPREV_CMD,
  input  logic [P_DATA_WIDTH-1:0]   iPREV_SOURCE0,
  input  logic [P_DATA_WIDTH-1:0]   iPREV_SOURCE1,
  input  logic [P_TAG_WIDTH-1:0]    iPREV_COMMIT_TAG,
  input  logic                      iPREV_WRITEBACK,
  input  logic [P_REG_WIDTH-1:0]    iPREV_DESTINATION_REGNAME,
  input  logic                      iPREV_FLAGS_WRITEBACK,
  input  logic [3:0]                iPREV_FLAGS_REGNAME,
  output logic                      oPREV_LOCK,
  input  logic                      iNEXT_READY,
  output logic                      oNEXT_VALID,
  output logic [P_TAG_WIDTH-1:0]    oNEXT_COMMIT_TAG,
  output logic                      oNEXT_WRITEBACK,
  output logic [P_REG_WIDTH-1:0]    oNEXT_DESTINATION_REGNAME,
  output logic [P_DATA_WIDTH-1:0]   oNEXT_DATA,
  output logic [4:0]                oNEXT_FLAG,
  output logic                      oNEXT_FLAGS_WRITEBACK,
  output logic [3:0]                oNEXT_FLAGS_REGNAME,
  output logic [$clog2(P_DEPTH):0]  oCOUNT,
  output logic                      oOVERFLOW
);
  localparam int AW = $clog2(P_DEPTH);
  localparam int LW = $clog2(P_DATA_WIDTH);
  localparam int M = P_DATA_WIDTH - 1;
  localparam int EW = P_TAG_WIDTH + P_REG_WIDTH + P_DATA_WIDTH + 11;
  logic [P_DATA_WIDTH-1:0] s0, s1, res;
  logic [LW-1:0] sh;
  logic cf, of, push, pop;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [EW-1:0] mem [P_DEPTH];
  logic [EW-1:0] entry;
  assign s0 = iPREV_SOURCE0;
  assign s1 = iPREV_SOURCE1;
  assign sh = s1[LW-1:0];
  always_comb begin
    res = '0;
    cf = 1'b0;
    of = 1'b0;
    case (iPREV_CMD)
      4'd0: res = s0;
      4'd1: res = s1;
      4'd2: begin
        {cf, res} = {1'b0, s0} + {1'b0, s1};
        of = (s0[M] == s1[M]) && (res[M] != s0[M]);
      end
      4'd3: begin
        {cf, res} = {1'b0, s0} - {1'b0, s1};
        of = (s0[M] != s1[M]) && (res[M] != s0[M]);
      end
      4'd4: res = s0 & s1;
      4'd5: res = s0 | s1;
      4'd6: res = s0 ^ s1;
      4'd7: res = ~s0;
      // a guard bit beside the operand catches the last bit shifted out
      4'd8: {cf, res} = {1'b0, s0} << sh;
      4'd9: {res, cf} = {s0, 1'b0} >> sh;
      4'd10: {res, cf} = $signed({s0, 1'b0}) >>> sh;
      4'd11: begin
        res = (s0 << sh) | (s0 >> ((LW+1)'(P_DATA_WIDTH) - (LW+1)'(sh)));
        cf = (sh != '0) & res[0];
      end
      default: ;
    endcase
  end
  assign entry = {iPREV_COMMIT_TAG, iPREV_WRITEBACK, iPREV_DESTINATION_REGNAME, res,
                  res[M], of, cf, ~^res[7:0], (res == '0), iPREV_FLAGS_WRITEBACK, iPREV_FLAGS_REGNAME};
  assign oPREV_LOCK = (oCOUNT == (AW+1)'(P_DEPTH));
  assign oNEXT_VALID = (oCOUNT != '0);
  assign push = iPREV_VALID && !oPREV_LOCK && !iFREE_EX;
  assign pop = oNEXT_VALID && iNEXT_READY && !iFREE_EX;
  assign {oNEXT_COMMIT_TAG, oNEXT_WRITEBACK, oNEXT_DESTINATION_REGNAME, oNEXT_DATA,
          oNEXT_FLAG, oNEXT_FLAGS_WRITEBACK, oNEXT_FLAGS_REGNAME} = mem[rd_ptr];
  always_ff @(posedge iCLOCK or negedge inRESET)
    if (!inRESET || iFREE_EX) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      oCOUNT <= '0;
      oOVERFLOW <= 1'b0;
      for (int i = 0; i < P_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) mem[wr_ptr] <= entry;
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      oCOUNT <= oCOUNT + (AW+1)'(push) - (AW+1)'(pop);
      if (iPREV_VALID && oPREV_LOCK) oOVERFLOW <= 1'b1;
    end
endmodule

// File: tb/tb_execute_port_buffered.sv
// tb_execute_port_buffered: directed scenario tasks with hand-computed expectations.
module tb_execute_port_buffered;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic free_ex = 1'b0, valid = 1'b0, wb = 1'b0, fwb = 1'b0, ready = 1'b0;
  logic [3:0] cmd = '0, freg = '0;
  logic [31:0] src0 = '0, src1 = '0;
  logic [5:0] tag = '0, dreg = '0;
  logic lock, nvalid, nwb, nfwb, ovf;
  logic [5:0] ntag, ndreg;
  logic [31:0] ndata;
  logic [4:0] nflag;
  logic [3:0] nfreg;
  logic [2:0] count;
  int pass = 0, total = 0;

  execute_port_buffered dut (
    .iCLOCK(clk), .inRESET(rstn), .iFREE_EX(free_ex), .iPREV_VALID(valid),
    .iPREV_CMD(cmd), .iPREV_SOURCE0(src0), .iPREV_SOURCE1(src1),
    .iPREV_COMMIT_TAG(tag), .iPREV_WRITEBACK(wb), .iPREV_DESTINATION_REGNAME(dreg),
    .iPREV_FLAGS_WRITEBACK(fwb), .iPREV_FLAGS_REGNAME(freg), .oPREV_LOCK(lock),
    .iNEXT_READY(ready), .oNEXT_VALID(nvalid), .oNEXT_COMMIT_TAG(ntag),
    .oNEXT_WRITEBACK(nwb), .oNEXT_DESTINATION_REGNAME(ndreg), .oNEXT_DATA(ndata),
    .oNEXT_FLAG(nflag), .oNEXT_FLAGS_WRITEBACK(nfwb), .oNEXT_FLAGS_REGNAME(nfreg),
    .oCOUNT(count), .oOVERFLOW(ovf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, input logic [5:0] t);
    valid = 1'b1; cmd = c; src0 = a; src1 = b; tag = t;
  endtask

  task automatic test_reset();
    total++; if (nvalid !== 1'b0) $display("FAIL reset_valid: got %b want 0", nvalid); else pass++;
    total++; if (lock !== 1'b0) $display("FAIL reset_lock: got %b want 0", lock); else pass++;
    total++; if (count !== 3'd0) $display("FAIL reset_count: got %0d want 0", count); else pass++;
    total++; if (ndata !== 32'h0 || ntag !== 6'h0 || nflag !== 5'h0) $display("FAIL reset_fields: got data %h tag %h flag %b want 0", ndata, ntag, nflag); else pass++;
    total++; if (ovf !== 1'b0) $display("FAIL reset_overflow: got %b want 0", ovf); else pass++;
  endtask

  task automatic test_add();
    ready = 1'b1;
    issue(4'd2, 32'hFFFF_FFFF, 32'd1, 6'd5);
    total++; if (nvalid !== 1'b0) $display("FAIL add_latency: got valid %b want 0", nvalid); else pass++;
    step();
    valid = 1'b0;
    total++; if (nvalid !== 1'b1) $display("FAIL add_valid: got %b want 1", nvalid); else pass++;
    total++; if (ndata !== 32'h0) $display("FAIL add_data: got %h want 0", ndata); else pass++;
    total++; if (nflag !== 5'b00111) $display("FAIL add_flag: got %b want 00111", nflag); else pass++;
    total++; if (ntag !== 6'd5) $display("FAIL add_tag: got %0d want 5", ntag); else pass++;
    step();
    total++; if (nvalid !== 1'b0) $display("FAIL add_pop: got valid %b want 0", nvalid); else pass++;
  endtask

  task automatic test_fill_lock();
    ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      issue(4'd3, 32'd7, 32'd3, 6'(i));
      step();
    end
    total++; if (count !== 3'd4) $display("FAIL fill_count: got %0d want 4", count); else pass++;
    total++; if (lock !== 1'b1) $display("FAIL fill_lock: got %b want 1", lock); else pass++;
    issue(4'd0, 32'd99, 32'd0, 6'd9);
    step();
    valid = 1'b0;
    total++; if (ovf !== 1'b1) $display("FAIL fill_overflow: got %b want 1", ovf); else pass++;
    total++; if (count !== 3'd4) $display("FAIL fill_drop: got count %0d want 4", count); else pass++;
    ready = 1'b1;
    issue(4'd0, 32'd77, 32'd0, 6'd10);
    total++; if (ntag !== 6'd1 || ndata !== 32'd4 || nflag !== 5'b00000) $display("FAIL fill_head1: got tag %0d data %0d flag %b want 1 4 00000", ntag, ndata, nflag); else pass++;
    step();
    valid = 1'b0;
    total++; if (count !== 3'd3) $display("FAIL fullpop_count: got %0d want 3", count); else pass++;
    total++; if (lock !== 1'b0) $display("FAIL fullpop_lock: got %b want 0", lock); else pass++;
    for (int i = 2; i <= 4; i++) begin
      total++; if (ntag !== 6'(i) || ndata !== 32'd4) $display("FAIL fill_order: got tag %0d data %0d want %0d 4", ntag, ndata, i); else pass++;
      step();
    end
    total++; if (nvalid !== 1'b0 || count !== 3'd0) $display("FAIL fill_drain: got valid %b count %0d want 0 0", nvalid, count); else pass++;
  endtask

  task automatic test_back_to_back();
    ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      issue(4'd2, 32'(i), 32'd100, 6'(i));
      step();
      total++; if (nvalid !== 1'b1 || ntag !== 6'(i) || ndata !== 32'(i + 100)) $display("FAIL wrap_head: got valid %b tag %0d data %0d want 1 %0d %0d", nvalid, ntag, ndata, i, i + 100); else pass++;
      total++; if (count !== 3'd1) $display("FAIL wrap_count: got %0d want 1", count); else pass++;
    end
    valid = 1'b0;
    step();
    total++; if (nvalid !== 1'b0) $display("FAIL wrap_drain: got %b want 0", nvalid); else pass++;
  endtask

  task automatic test_flush();
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      issue(4'd1, 32'd0, 32'(i), 6'(20 + i));
      step();
    end
    valid = 1'b0;
    total++; if (count !== 3'd3 || ovf !== 1'b1) $display("FAIL flush_pre: got count %0d ovf %b want 3 1", count, ovf); else pass++;
    free_ex = 1'b1;
    ready = 1'b1;
    issue(4'd1, 32'd0, 32'hDEAD, 6'h3F);
    step();
    free_ex = 1'b0;
    valid = 1'b0;
    total++; if (count !== 3'd0 || nvalid !== 1'b0 || ovf !== 1'b0) $display("FAIL flush_clear: got count %0d valid %b ovf %b want 0 0 0", count, nvalid, ovf); else pass++;
    step();
    total++; if (nvalid !== 1'b0 || ntag === 6'h3F) $display("FAIL flush_discard: got valid %b tag %h want 0 and not 3f", nvalid, ntag); else pass++;
  endtask

  task automatic test_shift_reset();
    ready = 1'b0;
    issue(4'd10, 32'h8000_0000, 32'd4, 6'd7);
    step();
    issue(4'd8, 32'h1, 32'd1, 6'd8);
    total++; if (ndata !== 32'hF800_0000 || nflag !== 5'b10010) $display("FAIL sar_result: got data %h flag %b want f8000000 10010", ndata, nflag); else pass++;
    step();
    valid = 1'b0;
    total++; if (count !== 3'd2) $display("FAIL sar_count: got %0d want 2", count); else pass++;
    #2 rstn = 1'b0;
    #1;
    total++; if (nvalid !== 1'b0 || count !== 3'd0 || lock !== 1'b0) $display("FAIL async_reset: got valid %b count %0d lock %b want 0 0 0", nvalid, count, lock); else pass++;
    total++; if (ndata !== 32'h0 || ntag !== 6'h0 || nflag !== 5'h0) $display("FAIL async_fields: got data %h tag %h flag %b want 0", ndata, ntag, nflag); else pass++;
    step();
    #2 rstn = 1'b1;
    step();
    total++; if (count !== 3'd0) $display("FAIL release_count: got %0d want 0", count); else pass++;
    ready = 1'b1;
    issue(4'd2, 32'd1, 32'd2, 6'h21);
    step();
    valid = 1'b0;
    total++; if (nvalid !== 1'b1 || ntag !== 6'h21 || ndata !== 32'd3) $display("FAIL release_head: got valid %b tag %h data %0d want 1 21 3", nvalid, ntag, ndata); else pass++;
  endtask

  initial begin
    #3;
    test_reset();
    #10 rstn = 1'b1;
    step();
    test_add();
    test_fill_lock();
    test_back_to_back();
    test_flush();
    test_shift_reset();
    step();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
